// File: rtl/cpu_control_unit_if.sv
// Control bundle between the accumulator CPU sequencer and its datapath/memory.
// The sequencer side uses the master modport; the datapath/memory side uses slave.
interface cpu_control_unit_if #(
    parameter int ICNT_W = 16
) ();
    logic [3:0]        opcode;
    logic              acc_zero;
    logic              acc_neg;
    logic              mem_ready;
    logic              loadIR;
    logic              incPC;
    logic              loadPC;
    logic              mem_req;
    logic              mem_we;
    logic              addr_sel;
    logic              load_mdr;
    logic              loadACC;
    logic [2:0]        alu_op;
    logic              halted;
    logic              illegal;
    logic [ICNT_W-1:0] icount;

    modport master (
        input  opcode, acc_zero, acc_neg, mem_ready,
        output loadIR, incPC, loadPC, mem_req, mem_we, addr_sel,
               load_mdr, loadACC, alu_op, halted, illegal, icount
    );

    modport slave (
        output opcode, acc_zero, acc_neg, mem_ready,
        input  loadIR, incPC, loadPC, mem_req, mem_we, addr_sel,
               load_mdr, loadACC, alu_op, halted, illegal, icount
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle Moore sequencer for the 16-bit accumulator CPU: fetch, decode,
// memory access and execute with a req/ready memory handshake.
module cpu_control_unit #(
    parameter int ICNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cpu_control_unit_if.master   bus
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_LOADIR = 4'd2;
    localparam logic [3:0] S_DECODE = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_JUMP   = 4'd7;
    localparam logic [3:0] S_HALT   = 4'd8;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JN  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [3:0]        r_state;
    logic [3:0]        w_next;
    logic [3:0]        r_opcode;
    logic              r_illegal;
    logic [ICNT_W-1:0] r_icount;
    logic              w_undef;
    logic              w_retire;
    logic [2:0]        w_alu_op;

    assign w_undef = (bus.opcode >= 4'hB) && (bus.opcode <= 4'hE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  if (bus.mem_ready) w_next = S_LOADIR;
            S_LOADIR: w_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: w_next = S_MEMRD;
                    OP_STA: w_next = S_MEMWR;
                    OP_NOT: w_next = S_EXEC;
                    OP_JMP: w_next = S_JUMP;
                    OP_JZ:  w_next = bus.acc_zero ? S_JUMP : S_FETCH;
                    OP_JN:  w_next = bus.acc_neg  ? S_JUMP : S_FETCH;
                    OP_HLT: w_next = S_HALT;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMRD:  if (bus.mem_ready) w_next = S_EXEC;
            S_MEMWR:  if (bus.mem_ready) w_next = S_FETCH;
            S_EXEC:   w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    // An instruction retires on any entry into FETCH except the one right after reset.
    assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
            r_icount  <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_DECODE) && w_undef) r_illegal <= 1'b1;
            if (w_retire && (r_icount != {ICNT_W{1'b1}})) r_icount <= r_icount + 1'b1;
        end
    end

    // Latched copy keeps EXEC independent of IR changes after DECODE.
    always_ff @(posedge clk) begin
        if (r_state == S_DECODE) r_opcode <= bus.opcode;
    end

    always_comb begin
        w_alu_op = 3'd0;
        if (r_state == S_EXEC) begin
            case (r_opcode)
                OP_ADD:  w_alu_op = 3'd1;
                OP_SUB:  w_alu_op = 3'd2;
                OP_AND:  w_alu_op = 3'd3;
                OP_OR:   w_alu_op = 3'd4;
                OP_NOT:  w_alu_op = 3'd5;
                default: w_alu_op = 3'd0;
            endcase
        end
    end

    assign bus.loadIR   = (r_state == S_LOADIR);
    assign bus.incPC    = (r_state == S_LOADIR);
    assign bus.loadPC   = (r_state == S_JUMP);
    assign bus.mem_req  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign bus.mem_we   = (r_state == S_MEMWR);
    assign bus.addr_sel = (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign bus.load_mdr = (r_state == S_MEMRD) && bus.mem_ready;
    assign bus.loadACC  = (r_state == S_EXEC);
    assign bus.alu_op   = w_alu_op;
    assign bus.halted   = (r_state == S_HALT);
    assign bus.illegal  = r_illegal;
    assign bus.icount   = r_icount;
endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Multi-cycle sequencer for the 16-bit accumulator CPU; sits directly downstream of the instruction register and consumes its 4-bit `opcode`. It drives the instruction-register load (`loadIR`), program-counter, memory-request and accumulator/ALU controls. It sequences fetch, decode, memory access and execute through a Moore state machine with a ready/request memory handshake.

## Interface
- `ICNT_W`, default 16: width of the retired-instruction counter.
- `clk`, in, 1: single system clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `opcode`, in, 4: instruction-register opcode field; valid from the DECODE state onward.
- `acc_zero`, in, 1: accumulator equals zero.
- `acc_neg`, in, 1: accumulator bit 15.
- `mem_ready`, in, 1: memory completes the current request at this edge.
- `loadIR`, out, 1: instruction register captures memory data.
- `incPC`, out, 1: PC increments by 1.
- `loadPC`, out, 1: PC loads the IR address field.
- `mem_req`, out, 1: memory access request.
- `mem_we`, out, 1: write access (qualifies `mem_req`).
- `addr_sel`, out, 1: memory address source; 0 = PC, 1 = IR address.
- `load_mdr`, out, 1: datapath MDR captures read data.
- `loadACC`, out, 1: accumulator captures the ALU result.
- `alu_op`, out, 3: 0 pass MDR, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOT ACC.
- `halted`, out, 1: core stopped.
- `illegal`, out, 1: sticky flag, set when an undefined opcode is decoded.
- `icount`, out, ICNT_W: retired-instruction count.

## Operation
- **Opcodes:**
  - 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 NOT, 8 JMP, 9 JZ, A JN, F HLT.
  - B–E are undefined: set `illegal` and execute as NOP.
- **States:** IDLE, FETCH, LOADIR, DECODE, MEMRD, MEMWR, EXEC, JUMP, HALT.
- **Outputs:** all outputs except `load_mdr`, `illegal` and `icount` decode from state alone (Moore). Any output not listed for a state is 0.
- **IDLE:** no outputs asserted; goes to FETCH unconditionally.
- **FETCH:** `mem_req`=1, `addr_sel`=0. Holds while `mem_ready`=0; goes to LOADIR on an edge with `mem_ready`=1.
- **LOADIR:** `loadIR`=1, `incPC`=1; goes to DECODE.
- **DECODE:** no outputs asserted. Next state by opcode:
  - LDA/ADD/SUB/AND/OR → MEMRD.
  - STA → MEMWR.
  - NOT → EXEC.
  - JMP → JUMP.
  - JZ → JUMP if `acc_zero`, else FETCH.
  - JN → JUMP if `acc_neg`, else FETCH.
  - HLT → HALT.
  - NOP or undefined → FETCH.
- **MEMRD:** `mem_req`=1, `addr_sel`=1. `load_mdr` = `mem_ready` (combinational). Goes to EXEC on `mem_ready`, otherwise holds.
- **MEMWR:** `mem_req`=1, `mem_we`=1, `addr_sel`=1. Goes to FETCH on `mem_ready`, otherwise holds.
- **EXEC:** `loadACC`=1, `alu_op` from the opcode register; goes to FETCH.
- **JUMP:** `loadPC`=1; goes to FETCH.
- **HALT:** `halted`=1; absorbing, left only via `rst_n`.
- **`alu_op` outside EXEC:** 0.
- **`opcode` latching:** the opcode is latched internally in DECODE. EXEC uses the latched copy, so IR changes after DECODE have no effect.
- **`icount`:** +1 on every transition into FETCH, except IDLE→FETCH. This covers NOP, not-taken branches, STA, EXEC and JUMP completions. Saturates at all-ones with no wrap. HLT is not counted.
- **`illegal`:** registered; set on the DECODE edge when B–E is decoded; cleared only by reset.

## Timing
- **Reset:** `rst_n`=0 immediately forces state IDLE, `illegal`=0 and `icount`=0; every output reads 0. This applies even mid-handshake; an outstanding memory request is dropped.
- **After reset:** first rising edge after `rst_n` rises enters FETCH, so `mem_req` goes high one cycle after reset release.
- **Handshake:**
  - `mem_req` stays asserted and address/we stay stable until the edge where `mem_ready`=1 is sampled.
  - `mem_ready` outside FETCH, MEMRD or MEMWR is ignored.
  - `mem_ready` held high for back-to-back accesses is legal.
- **Latency with zero-wait memory (`mem_ready` tied 1):**
  - NOP, not-taken branch: 3 cycles.
  - STA, JMP, taken branch, NOT: 4 cycles.
  - LDA/ADD/SUB/AND/OR: 5 cycles.
  - Each memory wait cycle adds 1.
- **Simultaneous events:** `acc_zero` and `acc_neg` are sampled only on the DECODE edge.

## Test plan
- **Reset:** `mem_ready`=1, `rst_n` low then high. All outputs are 0 during reset; `mem_req`=1 and `addr_sel`=0 on the first cycle after release; `loadIR`=1 one cycle later.
- **LDA with wait states:** `opcode`=1, `mem_ready` low for 3 cycles in MEMRD.
  - `mem_req`=1 and `addr_sel`=1 held for 4 cycles.
  - `load_mdr` high only in the ready cycle.
  - Next cycle: `loadACC`=1, `alu_op`=0.
  - `icount`=1 afterwards.
- **ALU sweep:** ADD/SUB/AND/OR/NOT with zero-wait memory give `alu_op` = 1/2/3/4/5 in EXEC. Total 5,5,5,5,4 cycles; `icount`=5.
- **Branches:**
  - JZ with `acc_zero`=1: `loadPC`=1 in cycle 4.
  - JZ with `acc_zero`=0: back to FETCH in cycle 4, `loadPC` never high.
  - JN with `acc_neg`=1: taken.
- **Illegal, HLT, saturation:**
  - `opcode`=C: `illegal`=1 and stays 1, executes as a 3-cycle NOP.
  - `opcode`=F: `halted`=1 and held for 20 cycles with `mem_req`=0.
  - `icount` preloaded near 0xFFFF saturates at 0xFFFF.
- **Mid-handshake reset:** assert `rst_n`=0 during MEMWR with `mem_ready`=0. `mem_req` and `mem_we` drop to 0 asynchronously (before the next edge); after release the core restarts at FETCH with `icount`=0.
